// File: rtl/tail_light_seq.sv
// rtl/tail_light_seq.sv - sequential tail-light controller with step prescaler and PWM dimming
module tail_light_seq #(
  parameter int LAMPS       = 3,
  parameter int STEP_CYCLES = 4,
  parameter int PWM_BITS    = 8,
  parameter int DUTY_DAY    = 255,
  parameter int DUTY_NIGHT  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left,
  input  logic               right,
  input  logic               night,
  output logic [2*LAMPS-1:0] light,
  output logic               busy
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam int PW = $clog2(STEP_CYCLES);

  localparam logic [SW-1:0]       STEP_LAST = SW'(LAMPS);
  localparam logic [PW-1:0]       PRE_LAST  = PW'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DUTY_D    = PWM_BITS'(DUTY_DAY);
  localparam logic [PWM_BITS-1:0] DUTY_N    = PWM_BITS'(DUTY_NIGHT);

  typedef enum logic [1:0] {IDLE, RUN, HAZ, BLANK} state_t;

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [SW-1:0]       step_q, step_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                night_q;

  logic                tick;
  logic [PWM_BITS-1:0] duty;
  logic                pwm_on;
  logic [LAMPS-1:0]    side;

  assign tick = (pre_q == PRE_LAST);

  // State register; night is registered so outputs depend on registers only
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      step_q  <= '0;
      pre_q   <= '0;
      pwm_q   <= '0;
      night_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      pre_q   <= pre_d;
      pwm_q   <= pwm_d;
      night_q <= night;
    end
  end

  // Next-state logic: requests are only sampled in IDLE, dir latched at start
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    step_d  = step_q;
    pwm_d   = pwm_q + PWM_BITS'(1);
    pre_d   = (state_q == IDLE) ? '0 : (tick ? '0 : pre_q + PW'(1));
    case (state_q)
      IDLE: begin
        if (left ^ right) begin
          state_d = RUN;
          step_d  = SW'(1);
          dir_d   = right;
        end else if (left & right) begin
          state_d = HAZ;
        end
      end
      RUN: begin
        if (tick) begin
          if (step_q == STEP_LAST) begin
            state_d = BLANK;
            step_d  = '0;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      HAZ: begin
        if (tick) state_d = BLANK;
      end
      BLANK: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lamp decode: all-ones duty is forced fully on rather than 2^N-1 of 2^N
  always_comb begin
    duty   = night_q ? DUTY_N : DUTY_D;
    pwm_on = (duty == '1) || (pwm_q < duty);
    side   = '0;
    light  = '0;
    busy   = (state_q != IDLE);
    case (state_q)
      RUN: begin
        for (int i = 0; i < LAMPS; i++) begin
          if (SW'(i) < step_q) side[i] = pwm_on;
        end
        light = dir_q ? {{LAMPS{1'b0}}, side} : {side, {LAMPS{1'b0}}};
      end
      HAZ:     light = {(2*LAMPS){pwm_on}};
      default: light = '0;
    endcase
  end

endmodule
